pll_reset_sequencer: RTL and testbench

//  Sits beside the system PLL, on the free-running 50 MHz reference clock.

---
 rtl/pll_reset_sequencer.sv | 167 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// ============================================================================
//  Module      : pll_reset_sequencer
//  Description : Runs from the 50 MHz reference clock beside the system PLL.
//                Pulses the PLL reset, synchronises (and optionally filters)
//                the asynchronous locked flag, retries on lock timeout and
//                holds core reset low until the PLL has stayed locked for a
//                settle window.
//                Optional macro: PLL_LOCK_FILTER_EN enables a glitch filter
//                on the rising edge of the synchronised locked flag.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 500000,
  parameter int SETTLE_CYCLES = 1024,
  parameter int FILTER_CYCLES = 8,
  parameter int CNT_W         = 20
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       core_rst_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [3:0] retries
);

  // Terminal counts for each timed state.
  localparam logic [CNT_W-1:0] C_RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       C_RETRY_MAX    = 4'hF;

  // One-hot encoding: each output is a single state flop, so it cannot glitch.
  typedef enum logic [3:0] {
    S_PLL_RST   = 4'b0001,
    S_WAIT_LOCK = 4'b0010,
    S_SETTLE    = 4'b0100,
    S_RUN       = 4'b1000
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retries_q, retries_d;
  logic             lock_lost_q, lock_lost_d;
  logic             sync1_q;
  logic             sync2_q;
  logic             w_locked_f;

  // Two-flop synchroniser for the asynchronous PLL locked flag.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

`ifdef PLL_LOCK_FILTER_EN
  localparam int              C_FW          = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [C_FW-1:0] C_FILTER_LAST = C_FW'(FILTER_CYCLES - 1);

  logic [C_FW-1:0] fcnt_q;
  logic            filt_q;

  // Rise only after FILTER_CYCLES consecutive synchronised highs; any low clears.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      filt_q <= 1'b0;
    end else if (!sync2_q) begin
      fcnt_q <= '0;
      filt_q <= 1'b0;
    end else if (fcnt_q == C_FILTER_LAST) begin
      filt_q <= 1'b1;
    end else begin
      fcnt_q <= fcnt_q + C_FW'(1);
    end
  end

  // Gating with the live synchronised flag keeps the fall path as fast as unfiltered.
  assign w_locked_f = sync2_q & filt_q;
`else
  assign w_locked_f = sync2_q;
`endif

  // Next-state logic; the counter restarts on every state change.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    retries_d   = retries_q;
    lock_lost_d = lock_lost_q;
    unique case (state_q)
      S_PLL_RST: begin
        if (cnt_q == C_RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      S_WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (w_locked_f) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else if (cnt_q == C_TIMEOUT_LAST) begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
          if (retries_q != C_RETRY_MAX) begin
            retries_d = retries_q + 4'd1;
          end
        end
      end
      S_SETTLE: begin
        // A lock drop takes priority over the settle window completing.
        if (!w_locked_f) begin
          state_d     = S_PLL_RST;
          cnt_d       = '0;
          lock_lost_d = 1'b1;
        end else if (cnt_q == C_SETTLE_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (!w_locked_f) begin
          state_d     = S_PLL_RST;
          cnt_d       = '0;
          lock_lost_d = 1'b1;
        end
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state register with synchronous reset into PLL_RST.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      retries_q   <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign pll_rst    = state_q[0];
  assign core_rst_n = state_q[3];
  assign ready      = state_q[3];
  assign lock_lost  = lock_lost_q;
  assign retries    = retries_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
// ============================================================================
//  Module      : tb_pll_reset_sequencer
//  Description : Self-checking bench for pll_reset_sequencer. A monitor logs
//                the edge index of every output transition; each scenario
//                task pushes the edges it expects and compares them in order.
//                Honours PLL_LOCK_FILTER_EN to match the design build.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pll_reset_sequencer;

  localparam int RST_C  = 4;
  localparam int TMO    = 100;
  localparam int SET_C  = 16;
  localparam int FILT_C = 8;
`ifdef PLL_LOCK_FILTER_EN
  localparam int FLT = FILT_C;
`else
  localparam int FLT = 0;
`endif

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst;
  logic       core_rst_n;
  logic       ready;
  logic       lock_lost;
  logic [3:0] retries;

  pll_reset_sequencer #(
    .RST_CYCLES   (RST_C),
    .LOCK_TIMEOUT (TMO),
    .SETTLE_CYCLES(SET_C),
    .FILTER_CYCLES(FILT_C),
    .CNT_W        (8)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .pll_rst   (pll_rst),
    .core_rst_n(core_rst_n),
    .ready     (ready),
    .lock_lost (lock_lost),
    .retries   (retries)
  );

  always #10 refclk = ~refclk;

  int tests = 0;
  int fails = 0;
  int ecyc  = 0;

  // Observed transitions (edge index) and expected ones.
  int         up_q[$], dn_q[$], prr_q[$], prf_q[$];
  logic [3:0] retr_q[$];
  int         exp_up_q[$], exp_dn_q[$], exp_prr_q[$], exp_prf_q[$];
  logic [3:0] exp_retr_q[$];

  logic prev_core = 1'b0;
  logic prev_pr   = 1'b0;

  // Edge counter: ecyc is the index of the most recent rising edge.
  always @(posedge refclk) ecyc <= ecyc + 1;

  // Monitor on the falling edge, away from the active edge.
  always @(negedge refclk) begin
    if (core_rst_n && !prev_core) up_q.push_back(ecyc);
    if (!core_rst_n && prev_core) dn_q.push_back(ecyc);
    if (pll_rst && !prev_pr) begin
      prr_q.push_back(ecyc);
      retr_q.push_back(retries);
    end
    if (!pll_rst && prev_pr) prf_q.push_back(ecyc);
    prev_core <= core_rst_n;
    prev_pr   <= pll_rst;
  end

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic clear_q();
    up_q.delete(); dn_q.delete(); prr_q.delete(); prf_q.delete(); retr_q.delete();
    exp_up_q.delete(); exp_dn_q.delete(); exp_prr_q.delete(); exp_prf_q.delete();
    exp_retr_q.delete();
  endtask

  // One reset edge; returns its index and clears logs once the monitor has seen it.
  task automatic do_reset(output int r);
    rst_n = 1'b0;
    tick();
    r = ecyc;
    rst_n = 1'b1;
    @(negedge refclk);
    #1;
    clear_q();
  endtask

  task automatic wait_up(input int budget);
    for (int i = 0; i < budget && up_q.size() == 0; i++) tick();
  endtask

  task automatic test_reset();
    pll_locked = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    tests++; if (pll_rst !== 1'b1)    begin fails++; $display("FAIL reset_pll_rst got=%b exp=1", pll_rst); end
    tests++; if (core_rst_n !== 1'b0) begin fails++; $display("FAIL reset_core_rst_n got=%b exp=0", core_rst_n); end
    tests++; if (ready !== 1'b0)      begin fails++; $display("FAIL reset_ready got=%b exp=0", ready); end
    tests++; if (lock_lost !== 1'b0)  begin fails++; $display("FAIL reset_lock_lost got=%b exp=0", lock_lost); end
    tests++; if (retries !== 4'd0)    begin fails++; $display("FAIL reset_retries got=%0d exp=0", retries); end
  endtask

  task automatic test_startup();
    int r, got, e;
    pll_locked = 1'b0;
    do_reset(r);
    for (int k = 1; k <= RST_C; k++) begin
      tick();
      tests++;
      if (pll_rst !== 1'(k < RST_C)) begin
        fails++; $display("FAIL startup_pll_rst edge=%0d got=%b exp=%b", k, pll_rst, k < RST_C);
      end
    end
    while (ecyc < r + 29) tick();
    pll_locked = 1'b1;
    exp_up_q.push_back(ecyc + 1 + SET_C + 2 + FLT);
    wait_up(200);
    tests++;
    if (up_q.size() == 0) begin
      fails++; $display("FAIL startup_core_up timeout exp_edge=%0d", exp_up_q[0]);
    end else begin
      got = up_q.pop_front(); e = exp_up_q.pop_front();
      if (got !== e) begin fails++; $display("FAIL startup_core_up got_edge=%0d exp_edge=%0d", got - r, e - r); end
    end
    tests++; if (ready !== 1'b1)   begin fails++; $display("FAIL startup_ready got=%b exp=1", ready); end
    tests++; if (retries !== 4'd0) begin fails++; $display("FAIL startup_retries got=%0d exp=0", retries); end
  endtask

  task automatic test_lock_drop();
    int e, got, ex, lf, w, settle;
    clear_q();
    e = ecyc;
    pll_locked = 1'b0;
    // Drop sampled at e+1..e+3; synchronised low from e+3, high again after e+5.
    exp_dn_q.push_back(e + 3);
    exp_prr_q.push_back(e + 3);
    exp_prf_q.push_back(e + 3 + RST_C);
    w  = e + 3 + RST_C;
    lf = e + 5 + FLT;
    settle = ((lf > w) ? lf : w) + 1;
    exp_up_q.push_back(settle + SET_C);
    tick(); tick(); tick();
    pll_locked = 1'b1;
    tick();
    tests++; if (lock_lost !== 1'b1) begin fails++; $display("FAIL drop_lock_lost got=%b exp=1", lock_lost); end
    wait_up(200);
    tests++;
    if (dn_q.size() == 0) begin fails++; $display("FAIL drop_core_down missing exp_edge=+3"); end
    else begin got = dn_q.pop_front(); ex = exp_dn_q.pop_front();
      if (got !== ex) begin fails++; $display("FAIL drop_core_down got_edge=+%0d exp_edge=+%0d", got - e, ex - e); end end
    tests++;
    if (prr_q.size() == 0) begin fails++; $display("FAIL drop_pll_rst_rise missing"); end
    else begin got = prr_q.pop_front(); ex = exp_prr_q.pop_front();
      if (got !== ex) begin fails++; $display("FAIL drop_pll_rst_rise got_edge=+%0d exp_edge=+%0d", got - e, ex - e); end end
    tests++;
    if (prf_q.size() == 0) begin fails++; $display("FAIL drop_pll_rst_fall missing"); end
    else begin got = prf_q.pop_front(); ex = exp_prf_q.pop_front();
      if (got !== ex) begin fails++; $display("FAIL drop_pll_rst_fall got_edge=+%0d exp_edge=+%0d", got - e, ex - e); end end
    tests++;
    if (up_q.size() == 0) begin fails++; $display("FAIL drop_reacquire timeout"); end
    else begin got = up_q.pop_front(); ex = exp_up_q.pop_front();
      if (got !== ex) begin fails++; $display("FAIL drop_reacquire got_edge=+%0d exp_edge=+%0d", got - e, ex - e); end end
  endtask

  task automatic test_retries();
    int r, got, ex;
    logic [3:0] gr, er;
    pll_locked = 1'b0;
    do_reset(r);
    for (int k = 1; k <= 17; k++) begin
      exp_prr_q.push_back(r + k * (RST_C + TMO));
      exp_retr_q.push_back((k > 15) ? 4'd15 : 4'(k));
    end
    for (int i = 0; i < 17 * (RST_C + TMO) + 20 && prr_q.size() < 17; i++) tick();
    for (int k = 1; k <= 17; k++) begin
      tests++;
      if (prr_q.size() == 0) begin
        fails++; $display("FAIL retry_pulse k=%0d missing", k);
      end else begin
        got = prr_q.pop_front(); ex = exp_prr_q.pop_front();
        gr = retr_q.pop_front(); er = exp_retr_q.pop_front();
        if (got !== ex) begin fails++; $display("FAIL retry_pulse k=%0d got_edge=%0d exp_edge=%0d", k, got - r, ex - r); end
        tests++;
        if (gr !== er) begin fails++; $display("FAIL retry_count k=%0d got=%0d exp=%0d", k, gr, er); end
      end
    end
    pll_locked = 1'b1;
    wait_up(300);
    tests++; if (ready !== 1'b1)    begin fails++; $display("FAIL retry_lock_ready got=%b exp=1", ready); end
    tests++; if (retries !== 4'd15) begin fails++; $display("FAIL retry_kept got=%0d exp=15", retries); end
  endtask

  task automatic test_reset_in_run();
    int r, got, ex, lf, settle;
    // Leave a sticky lock_lost behind so the reset has something to clear.
    clear_q();
    pll_locked = 1'b0;
    tick(); tick(); tick();
    pll_locked = 1'b1;
    wait_up(200);
    tests++; if (lock_lost !== 1'b1 || ready !== 1'b1) begin
      fails++; $display("FAIL rr_precond lock_lost=%b ready=%b exp=1/1", lock_lost, ready); end
    do_reset(r);
    tests++; if (pll_rst !== 1'b1)    begin fails++; $display("FAIL rr_pll_rst got=%b exp=1", pll_rst); end
    tests++; if (core_rst_n !== 1'b0) begin fails++; $display("FAIL rr_core_rst_n got=%b exp=0", core_rst_n); end
    tests++; if (ready !== 1'b0)      begin fails++; $display("FAIL rr_ready got=%b exp=0", ready); end
    tests++; if (lock_lost !== 1'b0)  begin fails++; $display("FAIL rr_lock_lost got=%b exp=0", lock_lost); end
    tests++; if (retries !== 4'd0)    begin fails++; $display("FAIL rr_retries got=%0d exp=0", retries); end
    // Locked held high: synchronised high after r+2.
    lf = r + 2 + FLT;
    settle = ((lf > r + RST_C) ? lf : r + RST_C) + 1;
    exp_prf_q.push_back(r + RST_C);
    exp_up_q.push_back(settle + SET_C);
    wait_up(200);
    tests++;
    if (prf_q.size() == 0) begin fails++; $display("FAIL rr_pll_rst_fall missing"); end
    else begin got = prf_q.pop_front(); ex = exp_prf_q.pop_front();
      if (got !== ex) begin fails++; $display("FAIL rr_pll_rst_fall got_edge=%0d exp_edge=%0d", got - r, ex - r); end end
    tests++;
    if (up_q.size() == 0) begin fails++; $display("FAIL rr_core_up timeout"); end
    else begin got = up_q.pop_front(); ex = exp_up_q.pop_front();
      if (got !== ex) begin fails++; $display("FAIL rr_core_up got_edge=%0d exp_edge=%0d", got - r, ex - r); end end
    tests++; if (lock_lost !== 1'b0) begin fails++; $display("FAIL rr_lock_lost_after got=%b exp=0", lock_lost); end
  endtask

  task automatic test_glitch();
    int r;
`ifndef PLL_LOCK_FILTER_EN
    int got, ex;
`endif
    pll_locked = 1'b0;
    do_reset(r);
    while (ecyc < r + 9) tick();
    pll_locked = 1'b1;
`ifndef PLL_LOCK_FILTER_EN
    // High sampled r+10..r+14, synchronised low seen by the FSM at r+17.
    exp_prr_q.push_back(r + 17);
`endif
    repeat (5) tick();
    pll_locked = 1'b0;
    repeat (30) tick();
`ifdef PLL_LOCK_FILTER_EN
    tests++; if (prr_q.size() != 0) begin fails++; $display("FAIL glitch_retry got=%0d pulses exp=0", prr_q.size()); end
    tests++; if (lock_lost !== 1'b0) begin fails++; $display("FAIL glitch_lock_lost got=%b exp=0", lock_lost); end
`else
    tests++;
    if (prr_q.size() == 0) begin fails++; $display("FAIL glitch_settle_exit missing"); end
    else begin got = prr_q.pop_front(); ex = exp_prr_q.pop_front();
      if (got !== ex) begin fails++; $display("FAIL glitch_settle_exit got_edge=%0d exp_edge=%0d", got - r, ex - r); end end
    tests++; if (lock_lost !== 1'b1) begin fails++; $display("FAIL glitch_lock_lost got=%b exp=1", lock_lost); end
`endif
    tests++; if (core_rst_n !== 1'b0) begin fails++; $display("FAIL glitch_core got=%b exp=0", core_rst_n); end
  endtask

  task automatic test_timeout_tie();
    int r, w, got, ex;
    pll_locked = 1'b0;
    do_reset(r);
    w = r + RST_C;
    // First sampled high so the filtered flag is seen on the cnt==TMO-1 edge.
    while (ecyc < w + TMO - 2 - FLT - 1) tick();
    pll_locked = 1'b1;
    exp_up_q.push_back(w + TMO + SET_C);
    wait_up(300);
    tests++;
    if (up_q.size() == 0) begin fails++; $display("FAIL tie_core_up timeout"); end
    else begin got = up_q.pop_front(); ex = exp_up_q.pop_front();
      if (got !== ex) begin fails++; $display("FAIL tie_core_up got_edge=%0d exp_edge=%0d", got - r, ex - r); end end
    tests++; if (retries !== 4'd0)  begin fails++; $display("FAIL tie_retries got=%0d exp=0", retries); end
    tests++; if (prr_q.size() != 0) begin fails++; $display("FAIL tie_retry_pulse got=%0d exp=0", prr_q.size()); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_lock_drop();
    test_retries();
    test_reset_in_run();
    test_glitch();
    test_timeout_tie();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
